// File: rtl/sigmoid_pkg.sv
// Shared constants and helpers for the sigmoid output packing path.
package sigmoid_pkg;

    localparam int unsigned Y_W       = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BYTE_MSB  = 14;
    localparam int unsigned BYTE_LSB  = 7;
    localparam int unsigned LANES_DEF = 4;
    localparam int unsigned DEPTH_DEF = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Smallest r with 2^r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Probability byte; values at or above 1.0 saturate to all ones.
    function automatic byte_t sat_byte(input logic sat, input byte_t raw);
        return sat ? '1 : raw;
    endfunction

endpackage

// File: rtl/sigmoid_pack_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only with a same-cycle pop.
module sigmoid_pack_fifo
    import sigmoid_pkg::*;
#(
    parameter int unsigned W     = 36,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned LW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [LW-1:0] level
);

    localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                level_q <= level_q + LW'(1);
            end else if (rd_en && !wr_en) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sigmoid_out_pack.sv
// Packs sigmoid probability bytes into LANES-wide words and queues them for write-back.
module sigmoid_out_pack
    import sigmoid_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CW    = 4,
    parameter int unsigned LW    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_y_valid,
    input  logic [Y_W-1:0]            i_y,
    input  logic                      i_flush,
    output logic [BYTE_W*LANES-1:0]   o_word,
    output logic [CW-1:0]             o_count,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LW-1:0]             o_level,
    output logic                      o_overflow
);

    localparam int unsigned WORD_W = BYTE_W * LANES;
    localparam int unsigned FIFO_W = WORD_W + CW;

    logic [LANES-1:0][BYTE_W-1:0] lane_q;
    logic [LANES-1:0][BYTE_W-1:0] lane_wr;
    logic [LANES-1:0][BYTE_W-1:0] lane_nxt;
    logic [CW-1:0]                k_q;
    logic [CW-1:0]                k_nxt;
    logic                         overflow_q;

    byte_t                        byte_in;
    logic                         push;
    logic [CW-1:0]                push_cnt;
    logic                         pop;
    logic [FIFO_W-1:0]            fifo_dout;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         unused_lsb;

    assign unused_lsb = ^i_y[BYTE_LSB-1:0];
    assign byte_in    = sat_byte(i_y[Y_W-1], i_y[BYTE_MSB:BYTE_LSB]);
    assign pop        = !fifo_empty && i_ready;

    // Lane write, push decision and packer clear.
    always_comb begin
        lane_wr  = lane_q;
        k_nxt    = k_q;
        push     = 1'b0;
        push_cnt = '0;
        if (i_y_valid) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (k_q == CW'(i)) begin
                    lane_wr[i] = byte_in;
                end
            end
            if (k_q == CW'(LANES - 1)) begin
                push     = 1'b1;
                push_cnt = CW'(LANES);
            end else if (i_flush) begin
                push     = 1'b1;
                push_cnt = k_q + CW'(1);
            end else begin
                k_nxt = k_q + CW'(1);
            end
        end else if (i_flush && (k_q != '0)) begin
            push     = 1'b1;
            push_cnt = k_q;
        end
        lane_nxt = lane_wr;
        if (push) begin
            lane_nxt = '0;
            k_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= '0;
            k_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q <= lane_nxt;
            k_q    <= k_nxt;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sigmoid_pack_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_cnt, lane_wr}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    assign o_valid    = !fifo_empty;
    assign o_word     = fifo_empty ? '0 : fifo_dout[WORD_W-1:0];
    assign o_count    = fifo_empty ? '0 : fifo_dout[FIFO_W-1:WORD_W];
    assign o_overflow = overflow_q;

endmodule
